// File: rtl/systolic_matmul_nxn.sv
// Output-stationary N x N systolic matrix multiplier with input skew, job FSM and row-serial readout.
// Optional macro SYSTOLIC_SIGNED_EN switches operands, products and results to two's complement.
module systolic_matmul_nxn #(
   parameter int N  = 3,
   parameter int DW = 8,
   parameter int K  = 3,
   parameter int AW = 2*DW + $clog2(K) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] a_col,
   input  logic [N*DW-1:0] b_row,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*AW-1:0] out_row,
   output logic            out_last,
   output logic            busy
);
   localparam int CW = $clog2(K + 1);
   localparam int FW = $clog2(2*N);
   localparam int RW = $clog2(N);
   localparam logic [CW-1:0] KLAST = CW'(K - 1);
   localparam logic [FW-1:0] FLAST = FW'(2*N - 2);
   localparam logic [RW-1:0] RLAST = RW'(N - 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   beat_cnt;
   logic [FW-1:0]   flush_cnt;
   logic [RW-1:0]   row;
   logic            accept, row_xfer;
   logic [DW-1:0]   a_inj [N];
   logic [DW-1:0]   b_inj [N];
   logic [DW-1:0]   a_skw [N];
   logic [DW-1:0]   b_skw [N];
   logic [DW-1:0]   sk_a  [N][N];
   logic [DW-1:0]   sk_b  [N][N];
   logic [DW-1:0]   a_q   [N][N];
   logic [DW-1:0]   b_q   [N][N];
   logic [DW-1:0]   a_in  [N][N];
   logic [DW-1:0]   b_in  [N][N];
   logic [AW-1:0]   acc   [N][N];

   function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [AW-1:0] ax, bx;
`ifdef SYSTOLIC_SIGNED_EN
      ax = {{(AW-DW){a[DW-1]}}, a};
      bx = {{(AW-DW){b[DW-1]}}, b};
`else
      ax = {{(AW-DW){1'b0}}, a};
      bx = {{(AW-DW){1'b0}}, b};
`endif
      // The low AW bits of the extended product are exact modulo 2^AW in both modes
      return ax * bx;
   endfunction

   assign in_ready  = (state == IDLE) || (state == COMPUTE);
   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign out_last  = out_valid && (row == RLAST);
   assign accept    = in_valid && in_ready;
   assign row_xfer  = out_valid && out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (K == 1) ? FLUSH : COMPUTE;
                  else        state_nxt = IDLE;
         COMPUTE: if (accept && (beat_cnt == KLAST)) state_nxt = FLUSH;
                  else                               state_nxt = COMPUTE;
         FLUSH:   if (flush_cnt == FLAST) state_nxt = DRAIN;
                  else                    state_nxt = FLUSH;
         DRAIN:   if (row_xfer && (row == RLAST)) state_nxt = IDLE;
                  else                            state_nxt = DRAIN;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat, flush and readout-row counters
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt  <= '0;
         flush_cnt <= '0;
         row       <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt  <= accept ? CW'(1) : CW'(0);
               flush_cnt <= '0;
               row       <= '0;
            end
            COMPUTE: if (accept) beat_cnt <= beat_cnt + CW'(1);
            FLUSH:   flush_cnt <= flush_cnt + FW'(1);
            DRAIN:   if (row_xfer) row <= (row == RLAST) ? RW'(0) : row + RW'(1);
            default: row <= '0;
         endcase
      end
   end

   // Bubbles and non-accepting states inject zero operands
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_inj[i] = accept ? a_col[i*DW +: DW] : {DW{1'b0}};
         b_inj[i] = accept ? b_row[i*DW +: DW] : {DW{1'b0}};
      end
      a_skw[0] = a_inj[0];
      b_skw[0] = b_inj[0];
      for (int i = 1; i < N; i++) begin
         a_skw[i] = sk_a[i][i-1];
         b_skw[i] = sk_b[i][i-1];
      end
      for (int i = 0; i < N; i++) begin
         a_in[i][0] = a_skw[i];
         b_in[0][i] = b_skw[i];
         for (int j = 1; j < N; j++) begin
            a_in[i][j] = a_q[i][j-1];
            b_in[j][i] = b_q[j-1][i];
         end
      end
   end

   // Skew delay lines and inter-PE operand registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               sk_a[i][j] <= '0;
               sk_b[i][j] <= '0;
               a_q[i][j]  <= '0;
               b_q[i][j]  <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            sk_a[i][0] <= a_inj[i];
            sk_b[i][0] <= b_inj[i];
            for (int d = 1; d < N; d++) begin
               sk_a[i][d] <= sk_a[i][d-1];
               sk_b[i][d] <= sk_b[i][d-1];
            end
            for (int j = 0; j < N; j++) begin
               a_q[i][j] <= a_in[i][j];
               b_q[i][j] <= b_in[i][j];
            end
         end
      end
   end

   // PE accumulators; IDLE restarts from zero so beat 0 lands in PE(0,0) on acceptance
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (reset) begin
               acc[i][j] <= '0;
            end else begin
               case (state)
                  IDLE:          acc[i][j] <= mul_ext(a_in[i][j], b_in[i][j]);
                  COMPUTE,
                  FLUSH:         acc[i][j] <= acc[i][j] + mul_ext(a_in[i][j], b_in[i][j]);
                  DRAIN:         acc[i][j] <= acc[i][j];
                  default:       acc[i][j] <= '0;
               endcase
            end
         end
      end
   end

   // Result row mux
   always_comb begin
      out_row = '0;
      if (state == DRAIN) begin
         for (int j = 0; j < N; j++) out_row[j*AW +: AW] = acc[row][j];
      end else begin
         out_row = '0;
      end
   end
endmodule
